// File: rtl/sel_pkg.sv
// sel_pkg
//   Shared constants for the sel_stream selector and anything that drives it.
//   MODE_FIXED : channel chosen by the external sel input
//   MODE_RR    : channel chosen by round-robin arbitration over in_valid
package sel_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage : sel_pkg

// File: rtl/rr_pick.sv
// rr_pick
//   Purely combinational rotate-priority search. Starting at the channel after
//   'last' and wrapping modulo N, it reports the first requesting channel.
//   Ports:
//     req       [N]  : request bit per channel
//     last      [SW] : most recently granted channel (search starts at last+1)
//     gnt_valid [1]  : at least one request is present
//     gnt       [SW] : index of the chosen channel (0 when gnt_valid is low)
module rr_pick #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt
);

  logic [SW-1:0]  start;
  logic [2*N-1:0] req_twice;
  logic [2*N-1:0] rotated;

  // last = N-1 wraps the search back to channel 0.
  assign start     = (int'(last) >= N - 1) ? '0 : last + 1'b1;
  assign req_twice = {req, req};
  // Rotating the doubled vector puts channel 'start' at bit 0, so the first set
  // bit among the low N bits is the nearest requester in search order.
  assign rotated   = req_twice >> start;

  always_comb begin
    int sum;
    gnt_valid = 1'b0;
    gnt       = '0;
    sum       = 0;
    for (int j = 0; j < N; j++) begin
      if (!gnt_valid && rotated[j]) begin
        gnt_valid = 1'b1;
        sum       = int'(start) + j;
        if (sum >= N) begin
          sum = sum - N;
        end
        gnt = SW'(sum);
      end
    end
  end

endmodule : rr_pick

// File: rtl/sel_stream.sv
// sel_stream
//   N-channel stream selector with a one-deep registered output stage. Each
//   cycle the output stage can accept a new beat (it is empty or draining), a
//   channel is chosen either by the external sel input or by round-robin, and
//   the chosen beat is captured together with its channel index.
//   Ports:
//     clk        : rising-edge clock
//     rst        : synchronous active-high reset
//     in_data    : N channels of W bits, channel i at [i*W +: W]
//     in_valid   : per-channel valid
//     in_ready   : per-channel ready, at most one bit high
//     mode       : MODE_FIXED (use sel) or MODE_RR (round-robin)
//     sel        : channel index used in fixed mode; values >= N never grant
//     out_data   : registered selected data
//     out_ch     : channel index that produced out_data
//     out_valid  : output stage holds a beat
//     out_ready  : consumer accepts the beat
module sel_stream
  import sel_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [SW-1:0] last;
  logic          rr_valid;
  logic [SW-1:0] rr_gnt;
  logic          gnt_valid;
  logic [SW-1:0] gnt;
  logic [W-1:0]  gnt_data;
  logic          load;

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_rr_pick (
    .req       (in_valid),
    .last      (last),
    .gnt_valid (rr_valid),
    .gnt       (rr_gnt)
  );

  // Grant source: in fixed mode only an in-range, valid sel can win; an
  // out-of-range sel simply never matches any channel index.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    if (mode == MODE_FIXED) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SW'(i) && in_valid[i]) begin
          gnt_valid = 1'b1;
          gnt       = sel;
        end
      end
    end else begin
      gnt_valid = rr_valid;
      gnt       = rr_gnt;
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SW'(i)) begin
        gnt_data = in_data[i*W +: W];
      end
    end
  end

  // The output stage can take a beat when empty or when its beat leaves now.
  assign load = !out_valid || out_ready;

  // Ready is suppressed during reset so producers keep their beats.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_ready[i] = !rst && load && gnt_valid && (gnt == SW'(i));
    end
  end

  // Output register and round-robin pointer. The pointer tracks grants in
  // both modes so arbitration stays fair across mode switches.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last      <= SW'(N - 1);
    end else if (load) begin
      if (gnt_valid) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_ch    <= gnt;
        last      <= gnt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule : sel_stream

// File: tb/tb_sel_stream.sv
// tb_sel_stream
//   Self-checking bench for sel_stream (N=4, W=8, SW=2). A behavioural model
//   tracks the output stage and the round-robin pointer as plain integers and
//   predicts in_ready and out_* for directed scenarios and a randomized run.
module tb_sel_stream;
  import sel_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;

  int vectors     = 0;
  int miscompares = 0;

  logic       m_valid;
  logic [W-1:0] m_data;
  int         m_ch;
  int         m_last;
  bit         xfer_found;
  int         xfer_ch;

  bit         pend  [N];
  logic [W-1:0] pdata [N];

  sel_stream #(
    .N  (N),
    .W  (W),
    .SW (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Which channel the rules say wins with the current inputs and model pointer.
  function automatic void modelGrant(output bit found, output int g);
    found = 0;
    g     = 0;
    if (mode == MODE_FIXED) begin
      if (int'(sel) < N && in_valid[sel]) begin
        found = 1;
        g     = int'(sel);
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!found && in_valid[c]) begin
          found = 1;
          g     = c;
        end
      end
    end
  endfunction

  // One clock cycle: predict and check in_ready, advance the model across the
  // edge, then check the registered outputs just after the edge.
  task automatic stepCycle();
    bit         found;
    int         g;
    bit         ld;
    logic [N-1:0] exp_rdy;
    #1;
    modelGrant(found, g);
    ld      = !m_valid || out_ready;
    exp_rdy = '0;
    if (!rst && ld && found) exp_rdy[g] = 1'b1;
    checkOutput("in_ready", in_ready, exp_rdy);
    xfer_found = (exp_rdy != 0);
    xfer_ch    = g;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = 0;
      m_last  = N - 1;
    end else if (ld) begin
      if (found) begin
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_ch    = g;
        m_last  = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("out_valid", out_valid, m_valid);
    checkOutput("out_data", out_data, m_data);
    checkOutput("out_ch", out_ch, m_ch);
  endtask

  // Drive control inputs for the next cycle, then run it.
  task automatic applyStimulus(input logic r, input logic md, input logic [SW-1:0] s,
                               input logic [N-1:0] v, input logic ordy);
    rst       = r;
    mode      = md;
    sel       = s;
    in_valid  = v;
    out_ready = ordy;
    stepCycle();
  endtask

  // Directed-only check of in_ready against a literal before the edge.
  task automatic peekReady(input string tag, input logic [N-1:0] exp);
    #1;
    checkOutput(tag, in_ready, exp);
  endtask

  // Directed scenarios followed by a randomized producer/consumer run.
  initial begin
    rst       = 1'b1;
    mode      = MODE_FIXED;
    sel       = '0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    m_valid   = 1'b0;
    m_data    = '0;
    m_ch      = 0;
    m_last    = N - 1;

    applyStimulus(1'b1, MODE_FIXED, 2'd0, 4'b0000, 1'b1);
    applyStimulus(1'b1, MODE_FIXED, 2'd0, 4'b0000, 1'b1);
    checkOutput("rst_valid", out_valid, 1'b0);

    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'(8'h10 + i);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, MODE_RR, 2'd0, 4'b1111, 1'b1);
      if (k == 0) checkOutput("first_valid", out_valid, 1'b1);
      checkOutput("rr_seq", out_ch, k % N);
    end

    in_data[2*W +: W] = 8'hA5;
    rst = 1'b0; mode = MODE_FIXED; sel = 2'd2; in_valid = 4'b0100;
    peekReady("fix_rdy", 4'b0100);
    applyStimulus(1'b0, MODE_FIXED, 2'd2, 4'b0100, 1'b1);
    checkOutput("fix_data", out_data, 8'hA5);
    checkOutput("fix_ch", out_ch, 2);
    applyStimulus(1'b0, MODE_FIXED, 2'd2, 4'b0000, 1'b1);
    checkOutput("fix_empty", out_valid, 1'b0);

    in_data[0 +: W] = 8'h11;
    applyStimulus(1'b0, MODE_FIXED, 2'd0, 4'b0001, 1'b1);
    sel = 2'd1; in_valid = 4'b1101;
    peekReady("nogrant_rdy", 4'b0000);
    applyStimulus(1'b0, MODE_FIXED, 2'd1, 4'b1101, 1'b1);
    checkOutput("nogrant_drain", out_valid, 1'b0);

    in_data[3*W +: W] = 8'h3C;
    applyStimulus(1'b0, MODE_FIXED, 2'd3, 4'b1000, 1'b1);
    in_data[3*W +: W] = 8'h7E;
    for (int k = 0; k < 5; k++) begin
      out_ready = 1'b0;
      peekReady("bp_rdy", 4'b0000);
      applyStimulus(1'b0, MODE_FIXED, 2'd3, 4'b1000, 1'b0);
      checkOutput("bp_data", out_data, 8'h3C);
      checkOutput("bp_ch", out_ch, 3);
    end
    out_ready = 1'b1;
    peekReady("bp_release_rdy", 4'b1000);
    applyStimulus(1'b0, MODE_FIXED, 2'd3, 4'b1000, 1'b1);
    checkOutput("bp_release_data", out_data, 8'h7E);

    applyStimulus(1'b0, MODE_FIXED, 2'd1, 4'b0010, 1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, MODE_RR, 2'd0, 4'b1010, 1'b1);
      checkOutput("rr_sparse", out_ch, (k % 2 == 0) ? 3 : 1);
    end

    applyStimulus(1'b1, MODE_RR, 2'd0, 4'b1111, 1'b0);
    checkOutput("rst_mid_valid", out_valid, 1'b0);
    checkOutput("rst_mid_data", out_data, 8'h00);
    checkOutput("rst_mid_ch", out_ch, 0);
    applyStimulus(1'b0, MODE_RR, 2'd0, 4'b1111, 1'b1);
    checkOutput("rst_prio", out_ch, 0);

    for (int i = 0; i < N; i++) begin
      pend[i]  = 0;
      pdata[i] = '0;
    end
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(2) != 0) begin
          pend[i]  = 1;
          pdata[i] = 8'($urandom);
        end
        in_valid[i]       = pend[i];
        in_data[i*W +: W] = pdata[i];
      end
      if ($urandom_range(7) == 0) mode = 1'($urandom_range(1));
      if ($urandom_range(3) == 0) sel = 2'($urandom_range(3));
      out_ready = ($urandom_range(3) != 0);
      rst       = ($urandom_range(60) == 0);
      stepCycle();
      if (xfer_found) pend[xfer_ch] = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_sel_stream
